// File: rtl/ahb_pkg.sv
// +--------------------------------------------------------------------+
// | ahb_pkg : shared AHB-Lite encodings, slave state enum, lane strobes |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } ahb_state_t;

  // Little-endian byte-lane enables for a transfer of the given size/offset.
  function automatic logic [3:0] byte_strobe(input logic [2:0] size,
                                             input logic [1:0] addr_lo);
    case (size)
      HSIZE_BYTE: byte_strobe = 4'b0001 << addr_lo;
      HSIZE_HALF: byte_strobe = addr_lo[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: byte_strobe = 4'b1111;
      default:    byte_strobe = 4'b0000;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_scratch_slave.sv
// +--------------------------------------------------------------------+
// | ahb_scratch_slave : AHB-Lite scratch RAM slave with wait states     |
// | Option macro AHB_SCRATCH_ERR_RESP_EN enables the ERROR response.    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module ahb_scratch_slave
  import ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
  parameter int          DEPTH       = 16,
  parameter int          WAIT_STATES = 1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int          c_aw   = $clog2(DEPTH);
  localparam logic [31:0] c_span = 32'(4 * DEPTH);
  localparam logic [2:0]  c_wait = 3'(WAIT_STATES);
`ifdef AHB_SCRATCH_ERR_RESP_EN
  localparam bit c_err_en = 1'b1;
`else
  localparam bit c_err_en = 1'b0;
`endif

  ahb_state_t       r_state;
  ahb_state_t       w_state_nxt;
  logic [31:0]      r_mem [DEPTH];
  logic [c_aw-1:0]  r_idx;
  logic [1:0]       r_addr_lo;
  logic [2:0]       r_size;
  logic             r_write;
  logic             r_legal;
  logic             r_dphase;
  logic [2:0]       r_cnt;

  logic [31:0]      w_offset;
  logic             w_active;
  logic             w_accept;
  logic             w_align_ok;
  logic             w_legal;
  logic             w_to_err;
  logic             w_done;
  logic             w_commit;
  logic [3:0]       w_strb;

  assign w_offset = HADDR - BASE_ADDR;
  assign w_active = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
  assign w_accept = HSEL && HREADY && w_active &&
                    ((r_state == ST_IDLE) || (r_state == ST_ERR2));

  // Addresses below BASE_ADDR wrap to a large offset and fail the range test.
  assign w_align_ok = (HSIZE == HSIZE_BYTE) ||
                      ((HSIZE == HSIZE_HALF) && !HADDR[0]) ||
                      ((HSIZE == HSIZE_WORD) && (HADDR[1:0] == 2'b00));
  assign w_legal  = (w_offset < c_span) && w_align_ok;
  assign w_to_err = w_accept && !w_legal && c_err_en;

  // A data phase ends in IDLE with HREADYOUT high; that is the commit point.
  assign w_done   = r_dphase && (r_state == ST_IDLE);
  assign w_commit = w_done && r_write && r_legal;
  assign w_strb   = byte_strobe(r_size, r_addr_lo);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_ERR2: begin
        if (w_to_err) begin
          w_state_nxt = ST_ERR1;
        end else if (w_accept && (c_wait != 3'd0)) begin
          w_state_nxt = ST_WAIT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (r_cnt == 3'd1) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ERR1: w_state_nxt = ST_ERR2;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    HRDATA    = '0;
    case (r_state)
      ST_WAIT: HREADYOUT = 1'b0;
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
      end
      ST_ERR2: HRESP = HRESP_ERROR;
      default: begin
        if (w_done && !r_write && r_legal) begin
          HRDATA = r_mem[r_idx];
        end
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_idx     <= '0;
      r_addr_lo <= '0;
      r_size    <= '0;
      r_write   <= 1'b0;
      r_legal   <= 1'b0;
      r_dphase  <= 1'b0;
      r_cnt     <= '0;
    end else begin
      if (w_accept) begin
        r_idx     <= w_offset[c_aw+1:2];
        r_addr_lo <= HADDR[1:0];
        r_size    <= HSIZE;
        r_write   <= HWRITE;
        r_legal   <= w_legal;
        r_dphase  <= !w_to_err;
        r_cnt     <= w_to_err ? 3'd0 : c_wait;
      end else begin
        if (w_done) begin
          r_dphase <= 1'b0;
        end
        if (r_state == ST_WAIT) begin
          r_cnt <= r_cnt - 3'd1;
        end
      end
    end
  end

  // Reads sample the array in their data phase, after any write committing on
  // the accepting edge, so an overlapping read already sees the merged word.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (w_strb[b]) begin
          r_mem[r_idx][8*b +: 8] <= HWDATA[8*b +: 8];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/ahb_scratch_slave.md
AHB_SCRATCH_SLAVE -- requirements
Module: ahb_scratch_slave

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h2000_0000, meaning byte address of word 0.
REQ-002 SHALL have parameter DEPTH, default 16, meaning number of 32-bit words (power of 2, 4..256).
REQ-003 SHALL have parameter WAIT_STATES, default 1, meaning data-phase wait cycles (0..7).
REQ-004 SHALL have port HCLK  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port HRESETn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port HSEL  input  1  slave select from decoder.
REQ-007 SHALL have port HADDR  input  32  address-phase byte address.
REQ-008 SHALL have port HTRANS  input  2  transfer type (IDLE/BUSY/NONSEQ/SEQ).
REQ-009 SHALL have port HWRITE  input  1  1 = write.
REQ-010 SHALL have port HSIZE  input  3  0 byte, 1 halfword, 2 word.
REQ-011 SHALL have port HWDATA  input  32  data-phase write data.
REQ-012 SHALL have port HREADY  input  1  bus-level ready (previous transfer done).
REQ-013 SHALL have port HREADYOUT  output  1  this slave's ready.
REQ-014 SHALL have port HRESP  output  1  0 OKAY, 1 ERROR.
REQ-015 SHALL have port HRDATA  output  32  read data.

Function
REQ-016 SHALL accept an address phase only when HSEL=1, HTRANS[1]=1 and HREADY=1; it registers HADDR, HWRITE, HSIZE.
REQ-017 SHALL respond to IDLE/BUSY or unselected cycles with HREADYOUT=1, HRESP=0, zero wait.
REQ-018 SHALL use states IDLE, WAIT, ERR1, ERR2: accept -> WAIT if WAIT_STATES>0 and legal, else data completes same cycle; illegal -> ERR1 -> ERR2 -> IDLE (or next accepted transfer).
REQ-019 SHALL hold HREADYOUT=0 for exactly WAIT_STATES cycles on legal transfers, down-counter loaded at acceptance.
REQ-020 SHALL commit writes at the cycle HREADYOUT=1 ends the data phase, sampling HWDATA then, byte lanes per HADDR[1:0]/HSIZE (little-endian).
REQ-021 SHALL drive HRDATA with the full addressed word while HREADYOUT=1 in a read data phase; 0 otherwise.
REQ-022 SHALL forward write data when a read address phase overlaps the final cycle of a write data phase to the same word (read returns merged new value).
REQ-023 SHALL treat as illegal: address outside [BASE_ADDR, BASE_ADDR+4*DEPTH), HSIZE>2, misalignment (halfword HADDR[0]=1, word HADDR[1:0]!=0).
REQ-024 SHALL, in ERR1, drive HREADYOUT=0, HRESP=1; in ERR2, HREADYOUT=1, HRESP=1; illegal writes SHALL NOT modify memory.
REQ-025 SHALL support back-to-back pipelined transfers with no idle cycle when WAIT_STATES=0.
REQ-026 SHALL index memory with (HADDR-BASE_ADDR)[log2(DEPTH)+1:2]; no wrap-around past DEPTH-1 (REQ-023 applies).

Reset
REQ-027 SHALL on HRESETn=0 immediately set HREADYOUT=1, HRESP=0, HRDATA=0, state IDLE, wait counter 0, all memory words 0.
REQ-028 SHALL discard any in-flight transfer on reset mid-wait or mid-error; no write commits.

Configuration
REQ-029 SHALL use macro AHB_SCRATCH_ERR_RESP_EN: defined -> REQ-023/024 error response; undefined -> illegal transfers complete OKAY with normal wait timing, writes dropped, reads return 0.

Structure
REQ-030 SHALL take HTRANS encodings, HSIZE encodings, HRESP codes and the state enum from shared package ahb_pkg.
REQ-031 SHALL be one flat module; byte-lane strobe generation MAY be a function in ahb_pkg, no sub-module.

Verification
REQ-032 SHALL cover: WAIT_STATES=1, word write 32'hDEADBEEF to BASE+4, read BASE+4 -> one low HREADYOUT cycle each, HRDATA=32'hDEADBEEF, HRESP=0.
REQ-033 SHALL cover: byte write 8'hA5 to BASE+6 over word 0 -> read BASE+4 returns 32'h00A5_0000.
REQ-034 SHALL cover: WAIT_STATES=0, write 32'h1234_5678 to BASE then immediate read BASE -> HRDATA=32'h1234_5678 (forwarding).
REQ-035 SHALL cover: word write to BASE+2 with macro defined -> HREADYOUT 0,1 with HRESP 1,1; memory unchanged; macro undefined -> OKAY, unchanged.
REQ-036 SHALL cover: write to BASE+64 (DEPTH=16) -> two-cycle ERROR; read BASE+64 -> ERROR, HRDATA=0.
REQ-037 SHALL cover: HRESETn asserted during WAIT of write 32'hFFFF_FFFF -> HREADYOUT=1 at once, later read returns 0.
